// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: handshake bundle between the pipeline datapath and pipe_ctrl.
// Signals:
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands and use flags
//   ex_is_load, ex_rd, ex_branch_taken     : EX-stage load/destination/branch info
//   mem_req, mem_ready                      : MEM-stage access pending / completing
//   pc_en, en_*                             : PC and pipeline-register enables
//   flush_if_id, flush_id_ex                : bubble injection into IF/ID, ID/EX
//   state, mem_timeout                      : controller FSM state and sticky halt flag
// Modports: master = datapath side, slave = pipe_ctrl side.
interface pipe_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_en;
    logic       en_if_id;
    logic       en_id_ex;
    logic       en_ex_mem;
    logic       en_mem_wb;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic [1:0] state;
    logic       mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, state, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, state, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush controller with memory-wait timeout.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   pif       : pipe_ctrl_if.slave (hazard/branch/memory inputs, enables/flushes/state out)
//   stall_cnt : 32-bit saturating count of cycles with pc_en=0 (only with PIPE_CTRL_PERF_EN)
// Parameter MEM_TIMEOUT (2..255): consecutive not-ready MEM_WAIT cycles before HALT.
// Optional feature macro: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave pif
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       hazard;
    logic       stall;
    logic       held;

    assign hazard = pif.ex_is_load && (pif.ex_rd != 5'd0) &&
                    ((pif.id_uses_rs1 && pif.id_rs1 == pif.ex_rd) ||
                     (pif.id_uses_rs2 && pif.id_rs2 == pif.ex_rd));
    assign stall  = pif.mem_req && !pif.mem_ready;
    // In MEM_WAIT the access is already outstanding, so only mem_ready matters.
    assign held   = (state_q == MEM_WAIT) ? !pif.mem_ready : stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN, FLUSH: begin
                if (stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    // The EX slot in FLUSH holds a bubble, so its branch flag is ignored.
                    state_d = (state_q == RUN && pif.ex_branch_taken) ? FLUSH : RUN;
                end
            end
            MEM_WAIT: begin
                if (!pif.mem_ready) begin
                    if (wait_cnt_q == LAST) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = pif.ex_branch_taken ? FLUSH : RUN;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        pif.pc_en       = 1'b0;
        pif.en_if_id    = 1'b0;
        pif.en_id_ex    = 1'b0;
        pif.en_ex_mem   = 1'b0;
        pif.en_mem_wb   = 1'b0;
        pif.flush_if_id = 1'b0;
        pif.flush_id_ex = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (!held) begin
                    pif.en_id_ex  = 1'b1;
                    pif.en_ex_mem = 1'b1;
                    pif.en_mem_wb = 1'b1;
                    if (pif.ex_branch_taken) begin
                        pif.pc_en       = 1'b1;
                        pif.en_if_id    = 1'b1;
                        pif.flush_if_id = 1'b1;
                        pif.flush_id_ex = 1'b1;
                    end else if (hazard) begin
                        // Freeze PC and IF/ID, push a bubble into EX for one cycle.
                        pif.flush_id_ex = 1'b1;
                    end else begin
                        pif.pc_en    = 1'b1;
                        pif.en_if_id = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pif.pc_en       = 1'b1;
                    pif.en_if_id    = 1'b1;
                    pif.en_id_ex    = 1'b1;
                    pif.en_ex_mem   = 1'b1;
                    pif.en_mem_wb   = 1'b1;
                    pif.flush_if_id = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pif.state       = state_q;
    assign pif.mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (!pif.pc_en && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= 32'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (MEM_TIMEOUT=4).
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] ADV = 7'b11111_00;
    localparam logic [6:0] STL = 7'b00000_00;
    localparam logic [6:0] BR  = 7'b11111_11;
    localparam logic [6:0] BUB = 7'b00111_01;
    localparam logic [6:0] FL  = 7'b11111_10;

    pipe_ctrl_if pif ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .pif(pif), .stall_cnt(stall_cnt));
`else
    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .pif(pif));
`endif

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {pif.pc_en, pif.en_if_id, pif.en_id_ex, pif.en_ex_mem, pif.en_mem_wb,
                  pif.flush_if_id, pif.flush_id_ex, pif.state, pif.mem_timeout};

    logic [9:0] exp_q[$];
    string      tag_q[$];

    function automatic logic [9:0] ex(input logic [6:0] en, input logic [1:0] st, input logic to);
        return {en, st, to};
    endfunction

    task automatic setin(input logic ld, input logic [4:0] rd, input logic u1, input logic [4:0] r1,
                         input logic u2, input logic [4:0] r2, input logic br, input logic req,
                         input logic rdy);
        pif.ex_is_load      = ld;
        pif.ex_rd           = rd;
        pif.id_uses_rs1     = u1;
        pif.id_rs1          = r1;
        pif.id_uses_rs2     = u2;
        pif.id_rs2          = r2;
        pif.ex_branch_taken = br;
        pif.mem_req         = req;
        pif.mem_ready       = rdy;
    endtask

    task automatic idle();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic compare();
        logic [9:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic now(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        compare();
    endtask

    task automatic step(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic chk_cnt(input string tag, input logic [31:0] e);
        checks++;
        assert (stall_cnt === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, stall_cnt, e);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1 now("reset", ex(ADV, 2'd0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step("idle", ex(ADV, 2'd0, 1'b0));
        setin(1, 5, 0, 0, 1, 5, 0, 0, 0);
        step("hazard_rs2", ex(BUB, 2'd0, 1'b0));
        setin(0, 5, 0, 0, 1, 5, 0, 0, 0);
        step("after_bubble", ex(ADV, 2'd0, 1'b0));
        setin(1, 7, 1, 7, 0, 0, 0, 0, 0);
        step("hazard_rs1", ex(BUB, 2'd0, 1'b0));
        setin(1, 0, 1, 0, 1, 0, 0, 0, 0);
        step("x0_no_hazard", ex(ADV, 2'd0, 1'b0));
        setin(1, 7, 0, 7, 0, 7, 0, 0, 0);
        step("unused_src", ex(ADV, 2'd0, 1'b0));

        setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("branch", ex(BR, 2'd0, 1'b0));
        idle();
        step("flush_state", ex(FL, 2'd2, 1'b0));
        step("flush_done", ex(ADV, 2'd0, 1'b0));

        setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mem_stall_run", ex(STL, 2'd0, 1'b0));
        step("mem_wait_1", ex(STL, 2'd1, 1'b0));
        step("mem_wait_2", ex(STL, 2'd1, 1'b0));
        setin(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("mem_ready", ex(ADV, 2'd1, 1'b0));
        idle();
        step("mem_back_run", ex(ADV, 2'd0, 1'b0));

        setin(1, 3, 1, 3, 0, 0, 1, 1, 0);
        step("combo_stall", ex(STL, 2'd0, 1'b0));
        setin(1, 3, 1, 3, 0, 0, 1, 1, 1);
        step("combo_ready_branch", ex(BR, 2'd1, 1'b0));
        idle();
        step("combo_flush", ex(FL, 2'd2, 1'b0));
        step("combo_run", ex(ADV, 2'd0, 1'b0));

        setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("branch2", ex(BR, 2'd0, 1'b0));
        setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("flush_mem_stall", ex(STL, 2'd2, 1'b0));
        setin(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("flush_wait_ready", ex(ADV, 2'd1, 1'b0));
        idle();
        step("flush_wait_run", ex(ADV, 2'd0, 1'b0));

        setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("hz_stall", ex(STL, 2'd0, 1'b0));
        setin(1, 9, 0, 0, 1, 9, 0, 1, 1);
        step("hz_on_ready", ex(BUB, 2'd1, 1'b0));
        idle();
        step("hz_run", ex(ADV, 2'd0, 1'b0));

        setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("to_enter", ex(STL, 2'd0, 1'b0));
        step("to_wait_1", ex(STL, 2'd1, 1'b0));
        step("to_wait_2", ex(STL, 2'd1, 1'b0));
        step("to_wait_3", ex(STL, 2'd1, 1'b0));
        step("to_wait_4", ex(STL, 2'd1, 1'b0));
        step("halt", ex(STL, 2'd3, 1'b1));
        setin(0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("halt_sticky", ex(STL, 2'd3, 1'b1));

        idle();
        #1 rst_n = 1'b0;
        #1 now("async_reset", ex(ADV, 2'd0, 1'b0));
        #1 rst_n = 1'b1;
        step("post_reset", ex(ADV, 2'd0, 1'b0));
        setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("post_reset_stall", ex(STL, 2'd0, 1'b0));
        step("post_reset_wait", ex(STL, 2'd1, 1'b0));

`ifdef PIPE_CTRL_PERF_EN
        idle();
        #1 rst_n = 1'b0;
        #1 chk_cnt("perf_reset", 32'd0);
        #1 rst_n = 1'b1;
        setin(1, 5, 0, 0, 1, 5, 0, 0, 0);
        step("perf_bubble", ex(BUB, 2'd0, 1'b0));
        idle();
        step("perf_adv", ex(ADV, 2'd0, 1'b0));
        setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("perf_stall", ex(STL, 2'd0, 1'b0));
        step("perf_wait_1", ex(STL, 2'd1, 1'b0));
        step("perf_wait_2", ex(STL, 2'd1, 1'b0));
        setin(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("perf_ready", ex(ADV, 2'd1, 1'b0));
        chk_cnt("perf_count", 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
